// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle shift execution unit. Accepts one shift request
//            (sll, srl, sra, rotl) through a start/done handshake and
//            computes it iteratively, STEP bit positions per clock. The
//            result is registered and held until the next completion.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-high reset
//            start  - request strobe, sampled only while idle
//            op     - 00 sll, 01 srl, 10 sra, 11 rotl
//            rt     - 32-bit operand, sampled with start
//            shamt  - shift amount 0..31, sampled with start
//            rd     - registered result
//            busy   - high while a request is in flight (SHIFT and DONE)
//            done   - one-cycle completion pulse
// Params   : STEP   - bit positions shifted per cycle (1, 2, 4 or 8)
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rt,
  input  logic [4:0]  shamt,
  output logic [31:0] rd,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] c_OP_SLL  = 2'b00;
  localparam logic [1:0] c_OP_SRL  = 2'b01;
  localparam logic [1:0] c_OP_SRA  = 2'b10;
  localparam logic [1:0] c_OP_ROTL = 2'b11;
  localparam logic [4:0] c_STEP    = 5'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_work;
  logic [1:0]  r_op;
  logic [4:0]  r_cnt;

  logic [4:0]  w_n;
  logic [4:0]  w_cnt_dec;
  logic [31:0] w_shifted;

  // Never shift past the remaining count, so the counter cannot underflow
  // and the final partial step lands exactly on the requested amount.
  assign w_n       = (r_cnt < c_STEP) ? r_cnt : c_STEP;
  assign w_cnt_dec = r_cnt - w_n;

  // One iteration of the selected shift by w_n positions. In SHIFT, w_n is
  // always non-zero, so the rotate's right-hand term shifts by at most 31.
  always_comb begin
    w_shifted = r_work;
    case (r_op)
      c_OP_SLL:  w_shifted = r_work << w_n;
      c_OP_SRL:  w_shifted = r_work >> w_n;
      // Bit 31 is never altered by sra, so it stays equal to the latched
      // operand's sign bit across all iterations.
      c_OP_SRA:  w_shifted = $unsigned($signed(r_work) >>> w_n);
      c_OP_ROTL: w_shifted = (r_work << w_n) | (r_work >> (6'd32 - {1'b0, w_n}));
      default:   w_shifted = r_work;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (shamt == 5'd0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cnt_dec == 5'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs. busy/done are derived from the next
  // state so they are true registers aligned with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work <= 32'h0;
      r_op   <= 2'b00;
      r_cnt  <= 5'd0;
      rd     <= 32'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (w_state_nxt != ST_IDLE);
      done <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work <= rt;
            r_op   <= op;
            r_cnt  <= shamt;
            // Zero shift: result is the operand itself for every op.
            if (shamt == 5'd0) begin
              rd <= rt;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= w_cnt_dec;
          if (w_cnt_dec == 5'd0) begin
            rd <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer. Two instances
//            (STEP=1 and STEP=4) share operand inputs and have separate
//            start strobes. Table-driven vectors plus hand-written
//            sequences for start-while-busy and reset mid-shift.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start1;
  logic        start4;
  logic [1:0]  op;
  logic [31:0] rt;
  logic [4:0]  shamt;

  logic [31:0] rd1;
  logic        busy1;
  logic        done1;
  logic [31:0] rd4;
  logic        busy4;
  logic        done4;

  logic        sel4;
  logic [31:0] s_rd;
  logic        s_busy;
  logic        s_done;

  int n_total;
  int n_pass;

  assign s_rd   = sel4 ? rd4   : rd1;
  assign s_busy = sel4 ? busy4 : busy1;
  assign s_done = sel4 ? done4 : done1;

  shift_sequencer #(.STEP(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .op    (op),
    .rt    (rt),
    .shamt (shamt),
    .rd    (rd1),
    .busy  (busy1),
    .done  (done1)
  );

  shift_sequencer #(.STEP(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .op    (op),
    .rt    (rt),
    .shamt (shamt),
    .rd    (rd4),
    .busy  (busy4),
    .done  (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        use4;
    logic [1:0]  op;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [31:0] exp_rd;
    int          k;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request on the selected instance and check timing and result.
  task automatic run_op(input logic use4, input logic [1:0] o, input logic [31:0] val,
                        input logic [4:0] sh, input logic [31:0] exp_rd, input int k,
                        input string name);
    int c;
    int busy_cnt;
    sel4 = use4;
    @(negedge clk);
    op    = o;
    rt    = val;
    shamt = sh;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);  // E0
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    // Scramble inputs: only the latched copies may matter.
    rt    = ~val;
    op    = ~o;
    shamt = ~sh;
    busy_cnt = 0;
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      c = i;
      if (s_busy) busy_cnt++;
      if (s_done) break;
    end
    chk({name, " done_cycle"}, 32'(c), 32'(k + 1));
    chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(k + 1));
    chk({name, " rd"}, s_rd, exp_rd);
    @(negedge clk);
    chk({name, " idle_after"}, {30'h0, s_busy, s_done}, 32'h0);
  endtask

  vec_t vecs[15];

  initial begin
    int dcount;
    int c;
    n_total = 0;
    n_pass  = 0;
    sel4    = 1'b0;
    start1  = 1'b0;
    start4  = 1'b0;
    op      = 2'b00;
    rt      = 32'h0;
    shamt   = 5'd0;

    vecs[0]  = '{1'b0, 2'b00, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 1,  "s1_sll1"};
    vecs[1]  = '{1'b0, 2'b00, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFF8, 3,  "s1_sll3"};
    vecs[2]  = '{1'b0, 2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000, 31, "s1_sll31"};
    vecs[3]  = '{1'b0, 2'b10, 32'h80000000, 5'd4,  32'hF8000000, 4,  "s1_sra4"};
    vecs[4]  = '{1'b0, 2'b01, 32'h80000000, 5'd4,  32'h08000000, 4,  "s1_srl4"};
    vecs[5]  = '{1'b0, 2'b11, 32'h80000001, 5'd3,  32'h0000000C, 3,  "s1_rotl3"};
    vecs[6]  = '{1'b0, 2'b00, 32'h12345678, 5'd0,  32'h12345678, 0,  "s1_sll0"};
    vecs[7]  = '{1'b0, 2'b10, 32'h12345678, 5'd0,  32'h12345678, 0,  "s1_sra0"};
    vecs[8]  = '{1'b0, 2'b11, 32'h12345678, 5'd8,  32'h34567812, 8,  "s1_rotl8"};
    vecs[9]  = '{1'b1, 2'b00, 32'h00000001, 5'd31, 32'h80000000, 8,  "s4_sll31"};
    vecs[10] = '{1'b1, 2'b00, 32'h00000001, 5'd5,  32'h00000020, 2,  "s4_sll5"};
    vecs[11] = '{1'b1, 2'b10, 32'h80000000, 5'd6,  32'hFE000000, 2,  "s4_sra6"};
    vecs[12] = '{1'b1, 2'b01, 32'hF0000000, 5'd9,  32'h00780000, 3,  "s4_srl9"};
    vecs[13] = '{1'b1, 2'b11, 32'h80000001, 5'd31, 32'hC0000000, 8,  "s4_rotl31"};
    vecs[14] = '{1'b1, 2'b01, 32'hCAFEBABE, 5'd0,  32'hCAFEBABE, 0,  "s4_srl0"};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_s1", {rd1[31:2], rd1[1:0] | {busy1, done1}}, 32'h0);
    chk("reset_s4", {rd4[31:2], rd4[1:0] | {busy4, done4}}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].use4, vecs[i].op, vecs[i].rt, vecs[i].shamt,
             vecs[i].exp_rd, vecs[i].k, vecs[i].name);
    end

    // Start while busy: pulses in SHIFT and in DONE must be ignored.
    sel4 = 1'b0;
    @(negedge clk);
    op = 2'b00; rt = 32'h00000001; shamt = 5'd4; start1 = 1'b1;
    @(posedge clk);  // E0
    #1 start1 = 1'b0;
    dcount = 0;
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done1) begin
        dcount++;
        if (c == 0) c = i;
      end
      if (i == 2 || i == 5) begin
        op = 2'b00; rt = 32'hFFFFFFFF; shamt = 5'd0; start1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
    end
    chk("busy_start done_cycle", 32'(c), 32'd5);
    chk("busy_start done_count", 32'(dcount), 32'd1);
    chk("busy_start rd", rd1, 32'h00000010);

    // Reset mid-shift: abort immediately, no done afterwards.
    @(negedge clk);
    op = 2'b00; rt = 32'h00000001; shamt = 5'd20; start1 = 1'b1;
    @(posedge clk);  // E0
    #1 start1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset busy", {31'h0, busy1}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midreset rd", rd1, 32'h0);
    chk("midreset busy_done", {30'h0, busy1, done1}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1 || busy1) dcount++;
    end
    chk("postreset quiet", 32'(dcount), 32'd0);
    run_op(1'b0, 2'b00, 32'h00000003, 5'd2, 32'h0000000C, 2, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
